// File: rtl/stage4_mem.sv
// Memory stage of the 5-stage pipeline: EX/MEM register, multi-cycle data-memory
// handshake with timeout, and the write-back / forwarding outputs.
module stage4_mem #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] ALUout,
    input  logic [15:0] writeData,
    input  logic [2:0]  writeReg,
    input  logic        RegWrite,
    input  logic        DMemWrite,
    input  logic        DMemEn,
    input  logic        MemToReg,
    input  logic        DMemDump,
    input  logic        Jump_Br,
    input  logic [15:0] pcPlus2,
    input  logic [15:0] instruction,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        stall,
    output logic [15:0] q_ALUout_s3,
    output logic        out_valid,
    output logic [15:0] ALUout_out,
    output logic [15:0] readData_out,
    output logic [15:0] pcPlus2_out,
    output logic [15:0] instruction_out,
    output logic [2:0]  writeReg_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic        Jump_Br_out,
    output logic        halt,
    output logic        err
);

    localparam int unsigned DW    = 16;
    localparam int unsigned RW    = 3;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, HALT} state_t;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] alu;
        logic [DW-1:0] wdata;
        logic [RW-1:0] wreg;
        logic          reg_write;
        logic          dmem_write;
        logic          dmem_en;
        logic          mem_to_reg;
        logic          dmem_dump;
        logic          jump_br;
        logic [DW-1:0] pc_plus2;
        logic [DW-1:0] instr;
    } lat_t;

    state_t           state_q;
    lat_t             lat_q;
    lat_t             lat_d;
    logic [DW-1:0]    rdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             abort_q;

    logic is_dump;
    logic is_memop;
    logic unaligned;
    logic req_c;
    logic stall_c;
    logic oval_c;
    logic halt_c;
    logic kill_rw_c;
    logic zero_rd_c;

    assign is_dump   = lat_q.valid & lat_q.dmem_dump;
    assign is_memop  = lat_q.valid & lat_q.dmem_en & ~lat_q.dmem_dump;
    assign unaligned = is_memop & lat_q.alu[0];

    // Control decode from the registered state and the EX/MEM register.
    always_comb begin
        req_c     = 1'b0;
        stall_c   = 1'b0;
        oval_c    = 1'b0;
        halt_c    = 1'b0;
        kill_rw_c = 1'b0;
        zero_rd_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_dump) begin
                    oval_c  = 1'b1;
                    halt_c  = 1'b1;
                    stall_c = 1'b1;
                end else if (unaligned) begin
                    oval_c    = 1'b1;
                    kill_rw_c = 1'b1;
                    zero_rd_c = 1'b1;
                end else if (is_memop) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                end else begin
                    oval_c = lat_q.valid;
                end
            end
            ACCESS: stall_c = 1'b1;
            DONE: begin
                oval_c    = 1'b1;
                kill_rw_c = abort_q;
            end
            HALT: begin
                stall_c = 1'b1;
                halt_c  = 1'b1;
            end
            default: stall_c = 1'b0;
        endcase
    end

    // EX/MEM register holds while the upstream stages are frozen.
    always_comb begin
        lat_d = lat_q;
        if (!stall_c) begin
            lat_d.valid      = in_valid;
            lat_d.alu        = ALUout;
            lat_d.wdata      = writeData;
            lat_d.wreg       = writeReg;
            lat_d.reg_write  = RegWrite;
            lat_d.dmem_write = DMemWrite;
            lat_d.dmem_en    = DMemEn;
            lat_d.mem_to_reg = MemToReg;
            lat_d.dmem_dump  = DMemDump;
            lat_d.jump_br    = Jump_Br;
            lat_d.pc_plus2   = pcPlus2;
            lat_d.instr      = instruction;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            lat_q <= lat_d;
            case (state_q)
                IDLE: begin
                    if (is_dump) begin
                        state_q <= HALT;
                    end else if (unaligned) begin
                        err_q <= 1'b1;
                    end else if (is_memop) begin
                        state_q <= ACCESS;
                        cnt_q   <= '0;
                        abort_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A completion in the last allowed cycle still counts as success.
                    if (mem_done) begin
                        if (!lat_q.dmem_write) begin
                            rdata_q <= mem_rdata;
                        end
                        state_q <= DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        abort_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req         = req_c;
    assign mem_wr          = req_c & lat_q.dmem_write;
    assign mem_addr        = lat_q.alu;
    assign mem_wdata       = lat_q.wdata;
    assign stall           = stall_c;
    assign out_valid       = oval_c;
    assign halt            = halt_c;
    assign err             = err_q;
    assign q_ALUout_s3     = lat_q.alu;
    assign ALUout_out      = lat_q.alu;
    assign readData_out    = (lat_q.mem_to_reg & ~zero_rd_c) ? rdata_q : '0;
    assign pcPlus2_out     = lat_q.pc_plus2;
    assign instruction_out = lat_q.instr;
    assign writeReg_out    = lat_q.wreg;
    assign RegWrite_out    = lat_q.reg_write & ~kill_rw_c;
    assign MemToReg_out    = lat_q.mem_to_reg;
    assign Jump_Br_out     = lat_q.jump_br;

endmodule

// File: tb/tb_stage4_mem.sv
// Bench for stage4_mem: table of pipeline vectors with a write-back scoreboard,
// plus directed sequences for load/store timing, misalignment, timeout, reset and halt.
module tb_stage4_mem;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] ALUout, writeData, pcPlus2, instruction;
    logic [2:0]  writeReg;
    logic        RegWrite, DMemWrite, DMemEn, MemToReg, DMemDump, Jump_Br;
    logic        mem_req, mem_wr, mem_done;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall, out_valid, halt, err;
    logic [15:0] q_ALUout_s3, ALUout_out, readData_out, pcPlus2_out, instruction_out;
    logic [2:0]  writeReg_out;
    logic        RegWrite_out, MemToReg_out, Jump_Br_out;

    always #5 clk = ~clk;

    stage4_mem #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ALUout(ALUout),
        .writeData(writeData), .writeReg(writeReg), .RegWrite(RegWrite),
        .DMemWrite(DMemWrite), .DMemEn(DMemEn), .MemToReg(MemToReg),
        .DMemDump(DMemDump), .Jump_Br(Jump_Br), .pcPlus2(pcPlus2),
        .instruction(instruction), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_done(mem_done), .stall(stall), .q_ALUout_s3(q_ALUout_s3),
        .out_valid(out_valid), .ALUout_out(ALUout_out), .readData_out(readData_out),
        .pcPlus2_out(pcPlus2_out), .instruction_out(instruction_out),
        .writeReg_out(writeReg_out), .RegWrite_out(RegWrite_out),
        .MemToReg_out(MemToReg_out), .Jump_Br_out(Jump_Br_out),
        .halt(halt), .err(err)
    );

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] rd;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [2:0]  wreg;
        logic        rw;
        logic        m2r;
        logic        jb;
        logic        hlt;
    } wb_t;

    typedef struct {
        logic        v;
        logic [15:0] alu;
        logic [15:0] wd;
        logic [2:0]  wreg;
        logic        rw, dwr, den, m2r, jb, dump;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] exp_rd;
        logic        exp_rw;
        logic        nowait;
    } vec_t;

    int   nvec = 0;
    int   nmis = 0;
    int   nreq = 0;
    int   resp_lat = 0;
    wb_t  sbq[$];
    vec_t vt[8];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic v, input logic [15:0] alu, input logic [15:0] wd,
                                 input logic [2:0] wreg, input logic rw, input logic dwr,
                                 input logic den, input logic m2r, input logic jb,
                                 input logic dump, input logic [15:0] pc,
                                 input logic [15:0] instr, input logic [15:0] exp_rd,
                                 input logic exp_rw, input logic nowait);
        vec_t t;
        t.v = v; t.alu = alu; t.wd = wd; t.wreg = wreg; t.rw = rw; t.dwr = dwr;
        t.den = den; t.m2r = m2r; t.jb = jb; t.dump = dump; t.pc = pc;
        t.instr = instr; t.exp_rd = exp_rd; t.exp_rw = exp_rw; t.nowait = nowait;
        return t;
    endfunction

    function automatic wb_t exp_of(input vec_t t, input logic [15:0] rd, input logic rw,
                                   input logic h);
        wb_t e;
        e.alu = t.alu; e.rd = rd; e.pc = t.pc; e.instr = t.instr; e.wreg = t.wreg;
        e.rw = rw; e.m2r = t.m2r; e.jb = t.jb; e.hlt = h;
        return e;
    endfunction

    // Memory model contents seen by loads.
    function automatic logic [15:0] rd_of(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hA5A5);
    endfunction

    task automatic drive(input vec_t t);
        in_valid = t.v; ALUout = t.alu; writeData = t.wd; writeReg = t.wreg;
        RegWrite = t.rw; DMemWrite = t.dwr; DMemEn = t.den; MemToReg = t.m2r;
        Jump_Br = t.jb; DMemDump = t.dump; pcPlus2 = t.pc; instruction = t.instr;
    endtask

    task automatic idle_in();
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Memory responder: answers each request resp_lat negedges later (0 = never).
    initial begin
        int pend;
        logic [15:0] pdata;
        pend = 0;
        pdata = '0;
        mem_done = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_done = 1'b1;
                    mem_rdata = pdata;
                end
            end
            if (mem_req) begin
                nreq++;
                if (resp_lat > 0) begin
                    pend = resp_lat;
                    pdata = rd_of(mem_addr);
                end
            end
        end
    end

    // Write-back monitor: every presented instruction must match the scoreboard head.
    initial begin
        wb_t e, got;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                got = {ALUout_out, readData_out, pcPlus2_out, instruction_out, writeReg_out,
                       RegWrite_out, MemToReg_out, Jump_Br_out, halt};
                if (sbq.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected_out_valid: got %0h expected none at %0t", got, $time);
                end else begin
                    e = sbq.pop_front();
                    chk("wb_out", 72'(got), 72'(e));
                end
            end
        end
    end

    initial begin
        vec_t t;
        int waited;
        int nreq0;

        vt[0] = mkv(1, 16'h0042, 16'h0000, 3'd1, 1, 0, 0, 0, 0, 0, 16'h0002, 16'h4042, 16'h0000, 1, 1);
        vt[1] = mkv(1, 16'h1234, 16'h0000, 3'd2, 1, 0, 0, 0, 0, 0, 16'h0004, 16'h4123, 16'h0000, 1, 1);
        vt[2] = mkv(0, 16'hFFFF, 16'h0000, 3'd3, 1, 0, 1, 1, 0, 0, 16'h0006, 16'hFFFF, 16'h0000, 0, 1);
        vt[3] = mkv(1, 16'h0100, 16'h0000, 3'd7, 1, 0, 0, 0, 1, 0, 16'h0008, 16'h3801, 16'h0000, 1, 1);
        vt[4] = mkv(1, 16'h0030, 16'h0000, 3'd4, 1, 0, 1, 1, 0, 0, 16'h000A, 16'h8C30, 16'hA595, 1, 1);
        vt[5] = mkv(1, 16'h0055, 16'h0000, 3'd5, 1, 0, 0, 0, 0, 0, 16'h000C, 16'h4555, 16'h0000, 1, 0);
        vt[6] = mkv(1, 16'h0020, 16'h1234, 3'd0, 0, 1, 1, 0, 0, 0, 16'h000E, 16'h9020, 16'h0000, 0, 1);
        vt[7] = mkv(1, 16'h00AA, 16'h0000, 3'd6, 1, 0, 0, 0, 0, 0, 16'h0010, 16'h46AA, 16'h0000, 1, 0);

        rst = 1'b1;
        idle_in();
        repeat (2) @(negedge clk);
        chk("reset_ctrl", 72'({stall, out_valid, err, halt, mem_req}), 72'(5'b0));
        chk("reset_data", 72'({ALUout_out, readData_out, q_ALUout_s3, writeReg_out}), 72'(0));
        rst = 1'b0;

        // Table: pass-throughs, a bubble, a load and a store through the scoreboard.
        resp_lat = 2;
        for (int i = 0; i < 8; i++) begin
            drive(vt[i]);
            waited = 0;
            while (stall && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 40) begin
                nvec++;
                nmis++;
                $display("FAIL accept_timeout_%0d: got stall=1 expected 0", i);
            end
            if (vt[i].nowait) chk($sformatf("nowait_%0d", i), 72'(waited), 72'(0));
            if (vt[i].v) sbq.push_back(exp_of(vt[i], vt[i].exp_rd, vt[i].exp_rw, 1'b0));
            @(negedge clk);
            idle_in();
        end
        repeat (6) @(negedge clk);
        chk("table_drained", 72'(sbq.size()), 72'(0));

        // Aligned load, completion 2 cycles after the request; upstream must hold.
        nreq0 = nreq;
        t = mkv(1, 16'h0010, 16'h0000, 3'd3, 1, 0, 1, 1, 0, 0, 16'h0020, 16'h8610, 0, 0, 0);
        drive(t);
        sbq.push_back(exp_of(t, 16'hBEEF, 1'b1, 1'b0));
        @(negedge clk);
        chk("ld_req", 72'({mem_req, mem_wr, stall, mem_addr}), 72'({3'b101, 16'h0010}));
        t = mkv(1, 16'h7777, 16'h0000, 3'd2, 1, 0, 0, 0, 0, 0, 16'h0022, 16'h4777, 0, 0, 0);
        drive(t);
        @(negedge clk);
        chk("ld_access1", 72'({mem_req, stall, q_ALUout_s3}), 72'({2'b01, 16'h0010}));
        @(negedge clk);
        chk("ld_access2", 72'({mem_req, stall, q_ALUout_s3}), 72'({2'b01, 16'h0010}));
        @(negedge clk);
        chk("ld_done", 72'({stall, out_valid, q_ALUout_s3}), 72'({2'b01, 16'h0010}));
        sbq.push_back(exp_of(t, 16'h0000, 1'b1, 1'b0));
        @(negedge clk);
        idle_in();
        chk("ld_one_req", 72'(nreq - nreq0), 72'(1));
        chk("ld_next_fwd", 72'(q_ALUout_s3), 72'(16'h7777));

        // Store, completion 1 cycle after the request.
        resp_lat = 1;
        nreq0 = nreq;
        t = mkv(1, 16'h0020, 16'h1234, 3'd0, 0, 1, 1, 0, 0, 0, 16'h0030, 16'h9234, 0, 0, 0);
        drive(t);
        sbq.push_back(exp_of(t, 16'h0000, 1'b0, 1'b0));
        @(negedge clk);
        idle_in();
        chk("st_req", 72'({mem_req, mem_wr, mem_addr, mem_wdata}), 72'({2'b11, 16'h0020, 16'h1234}));
        @(negedge clk);
        chk("st_access", 72'({mem_req, stall, out_valid}), 72'(3'b010));
        @(negedge clk);
        chk("st_done", 72'({stall, out_valid}), 72'(2'b01));
        @(negedge clk);
        chk("st_one_req", 72'({nreq - nreq0, 1'b0} | {31'(0), mem_req}), 72'({32'(1), 1'b0}));

        // Unaligned load: no request, result killed, sticky error.
        nreq0 = nreq;
        t = mkv(1, 16'h0011, 16'h0000, 3'd6, 1, 0, 1, 1, 0, 0, 16'h0040, 16'h8C11, 0, 0, 0);
        drive(t);
        sbq.push_back(exp_of(t, 16'h0000, 1'b0, 1'b0));
        @(negedge clk);
        idle_in();
        chk("unal_ctrl", 72'({mem_req, stall, out_valid}), 72'(3'b001));
        @(negedge clk);
        chk("unal_err", 72'(err), 72'(1'b1));
        repeat (3) @(negedge clk);
        chk("unal_err_sticky", 72'({err, nreq - nreq0}), 72'({1'b1, 32'(0)}));

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_clears_err", 72'(err), 72'(1'b0));

        // Timeout: no completion ever; DONE arrives 8 cycles after entering ACCESS.
        resp_lat = 0;
        t = mkv(1, 16'h0040, 16'h0000, 3'd1, 1, 0, 1, 1, 0, 0, 16'h0050, 16'h8240, 0, 0, 0);
        drive(t);
        sbq.push_back(exp_of(t, 16'h0000, 1'b0, 1'b0));
        @(negedge clk);
        idle_in();
        chk("to_req", 72'(mem_req), 72'(1'b1));
        for (int k = 1; k <= int'(TO); k++) begin
            @(negedge clk);
            chk($sformatf("to_access_%0d", k), 72'({stall, out_valid, err, mem_req}), 72'(4'b1000));
        end
        @(negedge clk);
        chk("to_done", 72'({stall, out_valid, err, readData_out}), 72'({3'b011, 16'h0000}));
        @(negedge clk);
        chk("to_after", 72'({out_valid, err}), 72'(2'b01));

        // Reset in the middle of an access; the late completion must be ignored.
        resp_lat = 6;
        t = mkv(1, 16'h0050, 16'h0000, 3'd2, 1, 0, 1, 1, 0, 0, 16'h0060, 16'h8450, 0, 0, 0);
        drive(t);
        @(negedge clk);
        idle_in();
        chk("rst_mid_req", 72'(mem_req), 72'(1'b1));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_state", 72'({stall, err, out_valid, ALUout_out}), 72'(0));
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("late_done_%0d", k), 72'({stall, out_valid, mem_req, err}), 72'(0));
        end

        // Halt: one write-back with halt, then frozen with no requests until reset.
        nreq0 = nreq;
        t = mkv(1, 16'h0099, 16'h0000, 3'd2, 0, 0, 0, 0, 0, 1, 16'h0070, 16'h6000, 0, 0, 0);
        drive(t);
        sbq.push_back(exp_of(t, 16'h0000, 1'b0, 1'b1));
        @(negedge clk);
        chk("halt_first", 72'({out_valid, halt, stall}), 72'(3'b111));
        drive(mkv(1, 16'h0070, 16'h0000, 3'd1, 1, 0, 1, 1, 0, 0, 16'h0072, 16'h8270, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("halt_hold_%0d", k), 72'({out_valid, halt, stall, mem_req}), 72'(4'b0110));
        end
        chk("halt_no_req", 72'(nreq - nreq0), 72'(0));
        idle_in();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("halt_rst", 72'({halt, stall}), 72'(2'b00));

        chk("sb_empty", 72'(sbq.size()), 72'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
